// File: rtl/puf_pkg.sv
// puf_pkg: shared types and default parameters for the PUF challenge scheduler
package puf_pkg;
  localparam int CHAL_W_DEF = 8;
  localparam int TIMEOUT_CYC_DEF = 1024;
  typedef enum logic [2:0] {IDLE, ARB, LAUNCH, WAIT, CAPTURE, HALT} sched_state_t;
endpackage

// File: rtl/puf_rr_arb.sv
// puf_rr_arb: two-way round-robin arbiter; a tie goes to the requester not served last
module puf_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_elig,
  input  logic       update,
  output logic [1:0] gnt
);
  logic last;
  always_comb gnt = (&req_elig) ? (last ? 2'b01 : 2'b10) : req_elig;
  // last=1 means PUF2 was served last, so PUF1 wins the first tie after reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last <= 1'b1;
    else if (update && |gnt) last <= gnt[1];
endmodule

// File: rtl/puf_chal_sched.sv
// puf_chal_sched: schedules two PUFs onto one shared evaluator with per-PUF challenge counters.
// Optional WAIT timeout is enabled by defining PUF_TIMEOUT_EN.
module puf_chal_sched
  import puf_pkg::*;
#(
  parameter int CHAL_W = CHAL_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              restart,
  input  logic [1:0]        req,
  output logic [1:0]        grant,
  output logic              eval_start,
  output logic              eval_sel,
  output logic [CHAL_W-1:0] eval_chal,
  input  logic              eval_done,
  input  logic              eval_resp,
  output logic              resp_valid,
  output logic              resp_sel,
  output logic [CHAL_W-1:0] resp_chal,
  output logic              resp_bit,
  output sched_state_t      ps,
  output logic              busy,
  output logic              all_done,
  output logic              timeout_err,
  output logic [CHAL_W-1:0] puf1_counter,
  output logic [CHAL_W-1:0] puf2_counter
);
  if (CHAL_W < 1 || TIMEOUT_CYC < 2) $error("puf_chal_sched: bad parameters");
  sched_state_t state, nxt;
  logic [CHAL_W-1:0] cnt1, cnt2, cur;
  logic [1:0] exh, exh_nx, elig, gnt;
  logic win, rbit, tmo;
  assign cur = win ? cnt2 : cnt1;
  assign exh_nx = exh | ({win, ~win} & {2{&cur}});
  assign elig = req & ~exh;
  puf_rr_arb u_arb (
    .clk(clk),
    .rst_n(rst_n),
    .req_elig(elig),
    .update(state == ARB && enable),
    .gnt(gnt)
  );
`ifdef PUF_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wcnt;
  logic tmo_r;
  assign tmo = state == WAIT && !eval_done && wcnt == TW'(TIMEOUT_CYC - 1);
  assign timeout_err = tmo_r;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wcnt <= '0;
      tmo_r <= 1'b0;
    end else begin
      wcnt <= state == WAIT ? wcnt + 1'b1 : '0;
      if (state == HALT && restart) tmo_r <= 1'b0;
      else if (tmo) tmo_r <= 1'b1;
    end
`else
  assign tmo = 1'b0;
  assign timeout_err = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = enable ? ARB : IDLE;
      ARB:     nxt = !enable ? IDLE : (|gnt ? LAUNCH : ARB);
      LAUNCH:  nxt = WAIT;
      WAIT:    nxt = (eval_done || tmo) ? CAPTURE : WAIT;
      CAPTURE: nxt = &exh_nx ? HALT : ARB;
      HALT:    nxt = restart ? IDLE : HALT;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt1 <= '0;
      cnt2 <= '0;
      exh <= '0;
      win <= 1'b0;
      rbit <= 1'b0;
    end else begin
      if (state == ARB && enable && |gnt) win <= gnt[1];
      if (state == WAIT && eval_done) rbit <= eval_resp;
      else if (tmo) rbit <= 1'b0;
      // the served counter advances on leaving CAPTURE, so resp_chal still shows the evaluated challenge
      if (state == CAPTURE) begin
        if (win) cnt2 <= cnt2 + 1'b1;
        else cnt1 <= cnt1 + 1'b1;
        exh <= exh_nx;
      end else if (state == HALT && restart) begin
        cnt1 <= '0;
        cnt2 <= '0;
        exh <= '0;
      end
    end
  always_comb begin
    busy = state == LAUNCH || state == WAIT || state == CAPTURE;
    grant = busy ? (win ? 2'b10 : 2'b01) : 2'b00;
    eval_start = state == LAUNCH;
    eval_sel = eval_start & win;
    eval_chal = eval_start ? cur : '0;
    resp_valid = state == CAPTURE;
    resp_sel = resp_valid & win;
    resp_chal = resp_valid ? cur : '0;
    resp_bit = resp_valid & rbit;
    all_done = state == HALT;
    ps = state;
    puf1_counter = cnt1;
    puf2_counter = cnt2;
  end
endmodule
